mult_div_unit: RTL

Multi-cycle multiply/divide unit that owns the HI/LO register pair in the E stage of the five-stage MIPS pipeline. It executes every instruction classified as `FUNC_MULTDIV`: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI and MTLO. It models fixed hardware latency with a down-counter. It exports `busy` and the HI/LO values to the hazard unit, which stalls the pipeline, and to the MFHI/MFLO result path.

---
 rtl/mult_div_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair in the E stage.
// Results are computed at acceptance and committed when the latency counter expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [31:0] r_hi, r_lo, r_phi, r_plo;
    logic [3:0]  r_cnt;
    logic        r_busy;

    logic               w_accept;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_mag_rs, w_mag_rt, w_den_s, w_den_u;
    logic [31:0]        w_uq, w_ur, w_quot_s, w_rem_s;
    logic [63:0]        w_res;
    logic               w_is_mul, w_is_div;

    assign w_accept = start && !cancel && !r_busy;

    assign w_prod_s = $signed(rs) * $signed(rt);
    assign w_prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide works on magnitudes; 0x80000000 is its own magnitude, so
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign w_mag_rs = rs[31] ? -rs : rs;
    assign w_mag_rt = rt[31] ? -rt : rt;
    assign w_den_s  = (rt == 32'd0) ? 32'd1 : w_mag_rt;
    assign w_den_u  = (rt == 32'd0) ? 32'd1 : rt;
    assign w_uq     = w_mag_rs / w_den_s;
    assign w_ur     = w_mag_rs % w_den_s;
    assign w_quot_s = (rs[31] ^ rt[31]) ? -w_uq : w_uq;
    assign w_rem_s  = rs[31] ? -w_ur : w_ur;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_res    = 64'd0;
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (op_e'(op))
            OP_MULT:  begin w_is_mul = 1'b1; w_res = w_prod_s; end
            OP_MULTU: begin w_is_mul = 1'b1; w_res = w_prod_u; end
            OP_MADD:  begin w_is_mul = 1'b1; w_res = {r_hi, r_lo} + w_prod_s; end
            OP_MADDU: begin w_is_mul = 1'b1; w_res = {r_hi, r_lo} + w_prod_u; end
            OP_MSUB:  begin w_is_mul = 1'b1; w_res = {r_hi, r_lo} - w_prod_s; end
            OP_MSUBU: begin w_is_mul = 1'b1; w_res = {r_hi, r_lo} - w_prod_u; end
            OP_DIV: begin
                w_is_div = 1'b1;
                w_res = (rt == 32'd0) ? {rs, 32'hFFFF_FFFF} : {w_rem_s, w_quot_s};
            end
            OP_DIVU: begin
                w_is_div = 1'b1;
                w_res = (rt == 32'd0) ? {rs, 32'hFFFF_FFFF} : {rs % w_den_u, rs / w_den_u};
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and all of them,
    // including the pending result pair, clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_phi  <= 32'd0;
            r_plo  <= 32'd0;
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
        end else if (w_accept) begin
            if (op == OP_MTHI) r_hi <= rs;
            if (op == OP_MTLO) r_lo <= rs;
            if (w_is_mul || w_is_div) begin
                {r_phi, r_plo} <= w_res;
                r_cnt          <= w_is_div ? DIV_LOAD : MULT_LOAD;
                r_busy         <= 1'b1;
            end
        end else if (r_busy) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_hi   <= r_phi;
                r_lo   <= r_plo;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
